dmem_port_arbiter: RTL and testbench

//  Shares the single-port 256x8 data RAM between two requesters: the ARM core
//  (read/write) and the VGA frame fetcher (read-only).
//  - Sits between the core/VGA and the RAM: muxes address, write data and

---
 rtl/dmem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data RAM between the ARM core (read/write) and the
// VGA fetcher (read-only); CPU has priority, a bounded wait guarantees VGA a slot.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int VGA_MAX_WAIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_rvalid_o,
  input  logic              vga_req_i,
  input  logic [ADDR_W-1:0] vga_addr_i,
  output logic              vga_gnt_o,
  output logic [DATA_W-1:0] vga_rdata_o,
  output logic              vga_rvalid_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_VGA  = 2'b10
  } owner_e;

  localparam logic [3:0]       MAX_WAIT_C = 4'(VGA_MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX_C  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

  owner_e            owner_q, owner_d;
  logic [3:0]        wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
  logic              cpu_gnt_s, vga_gnt_s;

  // Grant decision, read-owner tagging, VGA starvation and contention counting.
  always_comb begin
    cpu_gnt_s = 1'b0;
    vga_gnt_s = 1'b0;
    owner_d   = OWN_NONE;
    wait_d    = 4'd0;
    cnt_d     = cnt_q;
    if (rst_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      if (vga_req_i && (wait_q == MAX_WAIT_C)) begin
        vga_gnt_s = 1'b1;
      end else if (cpu_req_i) begin
        cpu_gnt_s = 1'b1;
      end else if (vga_req_i) begin
        vga_gnt_s = 1'b1;
      end else begin
        cpu_gnt_s = 1'b0;
        vga_gnt_s = 1'b0;
      end

      if (cpu_gnt_s && !cpu_we_i) begin
        owner_d = OWN_CPU;
      end else if (vga_gnt_s) begin
        owner_d = OWN_VGA;
      end else begin
        owner_d = OWN_NONE;
      end

      if (vga_req_i && !vga_gnt_s) begin
        wait_d = (wait_q >= MAX_WAIT_C) ? MAX_WAIT_C : (wait_q + 4'd1);
      end else begin
        wait_d = 4'd0;
      end

      if (cpu_req_i && vga_req_i && (cnt_q != CNT_MAX_C)) begin
        cnt_d = cnt_q + CNT_ONE_C;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // RAM port mux: idle cycles park the address on the CPU side with writes off.
  always_comb begin
    ram_addr_o  = cpu_addr_i;
    ram_wdata_o = cpu_wdata_i;
    ram_we_o    = 1'b0;
    if (rst_i) begin
      ram_addr_o  = {ADDR_W{1'b0}};
      ram_wdata_o = {DATA_W{1'b0}};
    end else if (vga_gnt_s) begin
      ram_addr_o = vga_addr_i;
    end else if (cpu_gnt_s) begin
      ram_we_o = cpu_we_i;
    end else begin
      ram_we_o = 1'b0;
    end
  end

  // Read return: RAM data arrives the cycle after the grant and is steered to its owner.
  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    vga_rdata_d = vga_rdata_q;
    case (owner_q)
      OWN_CPU: cpu_rdata_d = ram_rdata_i;
      OWN_VGA: vga_rdata_d = ram_rdata_i;
      default: begin
        cpu_rdata_d = cpu_rdata_q;
        vga_rdata_d = vga_rdata_q;
      end
    endcase
  end

  // Outputs are forced low while reset is held, including a return already in flight.
  always_comb begin
    cpu_gnt_o      = cpu_gnt_s;
    vga_gnt_o      = vga_gnt_s;
    cpu_rvalid_o   = 1'b0;
    vga_rvalid_o   = 1'b0;
    cpu_rdata_o    = {DATA_W{1'b0}};
    vga_rdata_o    = {DATA_W{1'b0}};
    conflict_cnt_o = {CNT_W{1'b0}};
    if (!rst_i) begin
      cpu_rvalid_o   = (owner_q == OWN_CPU);
      vga_rvalid_o   = (owner_q == OWN_VGA);
      cpu_rdata_o    = cpu_rdata_d;
      vga_rdata_o    = vga_rdata_d;
      conflict_cnt_o = cnt_q;
    end else begin
      cpu_rvalid_o = 1'b0;
      vga_rvalid_o = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q     <= OWN_NONE;
      wait_q      <= 4'd0;
      cnt_q       <= {CNT_W{1'b0}};
      cpu_rdata_q <= {DATA_W{1'b0}};
      vga_rdata_q <= {DATA_W{1'b0}};
    end else begin
      owner_q     <= owner_d;
      wait_q      <= wait_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      vga_rdata_q <= vga_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a policy-level model predicts grants and
// queues expected read returns; a negedge monitor retires them against the DUT.
module tb_dmem_port_arbiter;
  localparam int MAXW    = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, vga_req = 1'b0;
  logic [7:0]    cpu_addr = 8'h00, cpu_wdata = 8'h00, vga_addr = 8'h00;
  logic          cpu_gnt, cpu_rvalid, vga_gnt, vga_rvalid, ram_we;
  logic [7:0]    cpu_rdata, vga_rdata, ram_addr, ram_wdata;
  logic [7:0]    ram_rdata = 8'h00;
  logic [CW-1:0] conflict_cnt;

  dmem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .VGA_MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_rdata_o(cpu_rdata), .cpu_rvalid_o(cpu_rvalid),
    .vga_req_i(vga_req), .vga_addr_i(vga_addr),
    .vga_gnt_o(vga_gnt), .vga_rdata_o(vga_rdata), .vga_rvalid_o(vga_rvalid),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_we_o(ram_we),
    .ram_rdata_i(ram_rdata), .conflict_cnt_o(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [7:0] data; } ret_t;
  ret_t cpu_q[$];
  ret_t vga_q[$];

  int         total = 0, bad = 0, cyc = 0;
  int         m_wait = 0, m_cnt = 0;
  logic [7:0] ram [256];
  logic [7:0] shadow [256];
  bit         ram_init = 1'b0;
  logic [7:0] hold_c = 8'h00, hold_v = 8'h00;
  logic       d_cg, d_vg, d_crv, d_vrv;
  logic [7:0] d_crd, d_vrd;
  logic [CW-1:0] d_cnt;

  function automatic logic [7:0] init_val(input int a);
    if (a == 'h63) return 8'h3C;
    return 8'((a * 7) + 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous RAM seen by the arbiter.
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  // Monitor: retire expected returns exactly on their due cycle, else expect silence.
  always @(negedge clk) begin
    ret_t e;
    if (rst) begin
      cpu_q.delete();
      vga_q.delete();
      hold_c = 8'h00;
      hold_v = 8'h00;
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_vga_rvalid", vga_rvalid, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_vga_rdata", vga_rdata, 0);
    end else begin
      if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
        e = cpu_q.pop_front();
        hold_c = e.data;
        chk("cpu_rvalid", cpu_rvalid, 1);
      end else begin
        chk("cpu_rvalid_idle", cpu_rvalid, 0);
      end
      chk("cpu_rdata", cpu_rdata, hold_c);
      if (vga_q.size() > 0 && vga_q[0].due == cyc) begin
        e = vga_q.pop_front();
        hold_v = e.data;
        chk("vga_rvalid", vga_rvalid, 1);
      end else begin
        chk("vga_rvalid_idle", vga_rvalid, 0);
      end
      chk("vga_rdata", vga_rdata, hold_v);
    end
  end

  task automatic cycle(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic vr, input logic [7:0] va, output logic cg_e, output logic vg_e);
    rst = 1'b0;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    vga_req = vr; vga_addr = va;
    @(negedge clk);
    d_cg = cpu_gnt; d_vg = vga_gnt; d_crv = cpu_rvalid; d_vrv = vga_rvalid;
    d_crd = cpu_rdata; d_vrd = vga_rdata; d_cnt = conflict_cnt;
    vg_e = vr && (m_wait == MAXW);
    cg_e = !vg_e && cr;
    if (!vg_e && !cg_e) vg_e = vr;
    chk("cpu_gnt", cpu_gnt, cg_e);
    chk("vga_gnt", vga_gnt, vg_e);
    chk("ram_we", ram_we, cg_e && cw);
    chk("ram_addr", ram_addr, vg_e ? va : ca);
    chk("ram_wdata", ram_wdata, cd);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    if (cr && vr && m_cnt < CNT_MAX) m_cnt++;
    if (vr && !vg_e) m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
    else m_wait = 0;
    if (cg_e && cw) shadow[ca] = cd;
    if (cg_e && !cw) cpu_q.push_back('{cyc + 1, shadow[ca]});
    if (vg_e) vga_q.push_back('{cyc + 1, shadow[va]});
    @(posedge clk); #1;
  endtask

  task automatic rst_cycle();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h5A; vga_req = 1'b1; vga_addr = 8'hA5;
    @(negedge clk);
    d_crv = cpu_rvalid;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_vga_gnt", vga_gnt, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_conflict", conflict_cnt, 0);
    m_wait = 0;
    m_cnt = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic cg, vg, cp, cpw, vp;
    logic [7:0] cpa, cpd, vpa;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    @(posedge clk); #1;
    repeat (3) rst_cycle();

    // 1: CPU write alone, no return expected
    cycle(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, cg, vg);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, cg, vg);
    chk("t1_no_rvalid", d_crv, 0);
    // 2: CPU reads back the write
    cycle(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, cg, vg);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, cg, vg);
    chk("t2_cpu_rvalid", d_crv, 1);
    chk("t2_cpu_rdata", d_crd, 8'hA5);
    // 3: VGA alone reads preloaded location
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h63, cg, vg);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, cg, vg);
    chk("t3_vga_rvalid", d_vrv, 1);
    chk("t3_vga_rdata", d_vrd, 8'h3C);
    chk("t3_cpu_rvalid", d_crv, 0);
    // 4: sustained contention
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'h21, cg, vg);
      chk("t4_vga_gnt", d_vg, (i == 4 || i == 9) ? 1 : 0);
      chk("t4_cpu_gnt", d_cg, (i == 4 || i == 9) ? 0 : 1);
    end
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, cg, vg);
    chk("t4_conflict", d_cnt, 10);
    // 5: reset right after a CPU read grant
    cycle(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, cg, vg);
    rst_cycle();
    chk("t5_rvalid_in_rst", d_crv, 0);
    rst_cycle();
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, cg, vg);
    chk("t5_rvalid_after_rst", d_crv, 0);
    chk("t5_conflict", d_cnt, 0);
    // 6: alternating CPU/VGA reads
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cycle(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 8'h02, cg, vg);
      else            cycle(1'b0, 1'b0, 8'h01, 8'h00, 1'b1, 8'h02, cg, vg);
    end
    // randomized traffic with requesters holding until granted
    cp = 1'b0; vp = 1'b0; cpw = 1'b0; cpa = 8'h00; cpd = 8'h00; vpa = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_cycle();
        cp = 1'b0;
        vp = 1'b0;
      end else begin
        if (!cp && $urandom_range(0, 3) != 0) begin
          cp = 1'b1; cpw = 1'($urandom_range(0, 1));
          cpa = 8'($urandom_range(0, 15)); cpd = 8'($urandom);
        end
        if (!vp && $urandom_range(0, 2) != 0) begin
          vp = 1'b1; vpa = 8'($urandom_range(0, 15));
        end
        cycle(cp, cpw, cpa, cpd, vp, vpa, cg, vg);
        if (cg) cp = 1'b0;
        if (vg) vp = 1'b0;
      end
    end
    repeat (2) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, cg, vg);
    chk("drain_cpu_q", cpu_q.size(), 0);
    chk("drain_vga_q", vga_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
